ysyx_22050019_ex_mem: RTL and testbench

YSYX_22050019_EX_MEM -- requirements
Module: ysyx_22050019_ex_mem

---
 rtl/ysyx_22050019_pkg.sv | 26 ++
 rtl/ysyx_22050019_pipe_slot.sv | 34 +++
 rtl/ysyx_22050019_ex_mem.sv | 149 ++++++++++++++
 tb/tb_ysyx_22050019_ex_mem.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_pkg.sv
// ==========================================================================
// ysyx_22050019_pkg: shared state encoding and payload field widths, rev 1.0
// ==========================================================================
`default_nettype none

package ysyx_22050019_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } slot_state_e;

  localparam int INST_W  = 32;
  localparam int WMASK_W = 4;
  localparam int RWDTH_W = 6;
  localparam int REGA_W  = 5;

  // pc, alu_res, ram_wdata, csr data are XLEN wide; the three enables are 1 bit each
  function automatic int payload_width(input int xlen);
    return 4 * xlen + INST_W + WMASK_W + RWDTH_W + REGA_W + 3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22050019_pipe_slot.sv
// ==========================================================================
// ysyx_22050019_pipe_slot: resettable payload register with load and clear, rev 1.0
// ==========================================================================
`default_nettype none

module ysyx_22050019_pipe_slot #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
    end else if (clr_i) begin
      data_q <= RESET_VAL;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22050019_ex_mem.sv
// ==========================================================================
// ysyx_22050019_ex_mem: EX/MEM pipeline register with skid slot and flush, rev 1.0
// ==========================================================================
`default_nettype none

module ysyx_22050019_ex_mem
  import ysyx_22050019_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [31:0]       inst_i,
  input  logic [XLEN-1:0]   alu_res_i,
  input  logic              ram_we_i,
  input  logic [XLEN-1:0]   ram_wdata_i,
  input  logic [3:0]        mem_w_wdth_i,
  input  logic              ram_re_i,
  input  logic [5:0]        mem_r_wdth_i,
  input  logic              reg_we_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic [XLEN-1:0]   wdate_csr_reg_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   alu_res_o,
  output logic              ram_we_o,
  output logic [XLEN-1:0]   ram_wdata_o,
  output logic [3:0]        mem_w_wdth_o,
  output logic              ram_re_o,
  output logic [5:0]        mem_r_wdth_o,
  output logic              reg_we_o,
  output logic [4:0]        reg_waddr_o,
  output logic [XLEN-1:0]   wdate_csr_reg_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              load_pend_o,
  output logic [4:0]        fwd_waddr_o
);

  localparam int              PW       = payload_width(XLEN);
  localparam logic [PW-1:0]   SLOT_RST = {RESET_PC, {(PW - XLEN){1'b0}}};

  slot_state_e state_q, state_d;
  logic        in_fire, out_fire;
  logic        main_ld, main_from_skid, skid_ld, slot_clr;
  logic [PW-1:0] in_payload, main_d, main_q, skid_q;

  logic m_ram_we, m_ram_re, m_reg_we;

  assign in_payload = {pc_i, inst_i, alu_res_i, ram_we_i, ram_wdata_i, mem_w_wdth_i,
                       ram_re_i, mem_r_wdth_i, reg_we_i, reg_waddr_i, wdate_csr_reg_i};

  // Handshake flags depend only on registered state, never on ready_i
  assign ready_o  = (state_q != ST_FULL);
  assign valid_o  = (state_q == ST_ONE) || (state_q == ST_FULL);
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    slot_clr       = 1'b0;
    if (flush_i) begin
      state_d  = ST_EMPTY;
      slot_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            skid_ld = 1'b1;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_payload;

  ysyx_22050019_pipe_slot #(
    .WIDTH     (PW),
    .RESET_VAL (SLOT_RST)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (slot_clr),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  ysyx_22050019_pipe_slot #(
    .WIDTH     (PW),
    .RESET_VAL (SLOT_RST)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (slot_clr),
    .ld_i  (skid_ld),
    .d_i   (in_payload),
    .q_o   (skid_q)
  );

  assign {pc_o, inst_o, alu_res_o, m_ram_we, ram_wdata_o, mem_w_wdth_o,
          m_ram_re, mem_r_wdth_o, m_reg_we, reg_waddr_o, wdate_csr_reg_o} = main_q;

  // Stale payload in main must never trigger side effects once the entry has left
  assign ram_we_o    = valid_o & m_ram_we;
  assign ram_re_o    = valid_o & m_ram_re;
  assign reg_we_o    = valid_o & m_reg_we;
  assign load_pend_o = valid_o & m_ram_re;
  assign fwd_waddr_o = (valid_o & m_reg_we) ? reg_waddr_o : 5'd0;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050019_ex_mem.sv
// ==========================================================================
// tb_ysyx_22050019_ex_mem: directed vector table plus reset and scoreboard sequences, rev 1.0
// ==========================================================================
`default_nettype none

module tb_ysyx_22050019_ex_mem;

  localparam int          XLEN = 64;
  localparam logic [63:0] RPC  = 64'h3000;

  logic clk = 1'b0;
  logic rst_n, flush_i, valid_i, ready_o, ready_i, valid_o, load_pend_o;
  logic [63:0] pc_i, pc_o, alu_res_i, alu_res_o, ram_wdata_i, ram_wdata_o;
  logic [63:0] wdate_csr_reg_i, wdate_csr_reg_o;
  logic [31:0] inst_i, inst_o;
  logic        ram_we_i, ram_we_o, ram_re_i, ram_re_o, reg_we_i, reg_we_o;
  logic [3:0]  mem_w_wdth_i, mem_w_wdth_o;
  logic [5:0]  mem_r_wdth_i, mem_r_wdth_o;
  logic [4:0]  reg_waddr_i, reg_waddr_o, fwd_waddr_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_22050019_ex_mem #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .alu_res_i(alu_res_i), .ram_we_i(ram_we_i),
    .ram_wdata_i(ram_wdata_i), .mem_w_wdth_i(mem_w_wdth_i), .ram_re_i(ram_re_i),
    .mem_r_wdth_i(mem_r_wdth_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .wdate_csr_reg_i(wdate_csr_reg_i),
    .pc_o(pc_o), .inst_o(inst_o), .alu_res_o(alu_res_o), .ram_we_o(ram_we_o),
    .ram_wdata_o(ram_wdata_o), .mem_w_wdth_o(mem_w_wdth_o), .ram_re_o(ram_re_o),
    .mem_r_wdth_o(mem_r_wdth_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .wdate_csr_reg_o(wdate_csr_reg_o),
    .valid_o(valid_o), .ready_i(ready_i), .load_pend_o(load_pend_o), .fwd_waddr_o(fwd_waddr_o)
  );

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Table entries carry explicit flags; the remaining payload fields derive from pc
  task automatic set_payload(input logic [63:0] pc, input logic we, input logic re,
                             input logic rwe, input logic [4:0] wa);
    pc_i            = pc;
    inst_i          = pc[31:0] ^ 32'hDEAD_0000;
    alu_res_i       = ~pc;
    ram_wdata_i     = pc << 1;
    wdate_csr_reg_i = pc + 64'd7;
    mem_w_wdth_i    = pc[3:0] ^ 4'hA;
    mem_r_wdth_i    = pc[5:0] ^ 6'h15;
    ram_we_i        = we;
    ram_re_i        = re;
    reg_we_i        = rwe;
    reg_waddr_i     = wa;
  endtask

  task automatic set_rand_payload(input logic [63:0] pc);
    set_payload(pc, pc[2], pc[3], pc[4], pc[9:5]);
  endtask

  task automatic chk_entry(input string name, input logic [63:0] pc);
    logic [383:0] act, exp;
    act = {pc_o, inst_o, alu_res_o, ram_wdata_o, wdate_csr_reg_o, mem_w_wdth_o,
           mem_r_wdth_o, reg_waddr_o, ram_we_o, ram_re_o, reg_we_o, load_pend_o, fwd_waddr_o};
    exp = {pc, pc[31:0] ^ 32'hDEAD_0000, ~pc, pc << 1, pc + 64'd7, pc[3:0] ^ 4'hA,
           pc[5:0] ^ 6'h15, pc[9:5], pc[2], pc[3], pc[4], pc[3], (pc[4] ? pc[9:5] : 5'd0)};
    chk(name, act, exp);
  endtask

  typedef struct packed {
    logic        flush, valid, rdy;
    logic [63:0] pc;
    logic        we, re, rwe;
    logic [4:0]  wa;
    logic        e_valid, e_ready;
    logic [63:0] e_pc;
    logic        e_we, e_lp;
    logic [4:0]  e_fwd;
  } vec_t;

  localparam int NV = 14;
  vec_t tv [NV];

  logic [63:0] sb_q[$];
  logic [63:0] next_pc;
  logic        rdy_save, in_fire, out_fire;

  initial begin
    //        fl  v   r   pc            we  re  rwe wa     ev  er  epc           ewe elp efwd
    tv[0]  = '{0, 1, 1, 64'h8000_0000, 0, 0, 1, 5'd3,  1, 1, 64'h8000_0000, 0, 0, 5'd3};
    tv[1]  = '{0, 0, 1, 64'h0,         0, 0, 0, 5'd0,  0, 1, 64'h8000_0000, 0, 0, 5'd0};
    tv[2]  = '{0, 1, 0, 64'h100,       1, 0, 0, 5'd0,  1, 1, 64'h100,       1, 0, 5'd0};
    tv[3]  = '{0, 1, 0, 64'h104,       1, 0, 0, 5'd0,  1, 0, 64'h100,       1, 0, 5'd0};
    tv[4]  = '{0, 1, 0, 64'h108,       0, 0, 0, 5'd0,  1, 0, 64'h100,       1, 0, 5'd0};
    tv[5]  = '{0, 0, 1, 64'h0,         0, 0, 0, 5'd0,  1, 1, 64'h104,       1, 0, 5'd0};
    tv[6]  = '{0, 0, 1, 64'h0,         0, 0, 0, 5'd0,  0, 1, 64'h104,       0, 0, 5'd0};
    tv[7]  = '{0, 1, 0, 64'h200,       0, 1, 1, 5'd5,  1, 1, 64'h200,       0, 1, 5'd5};
    tv[8]  = '{0, 0, 0, 64'h0,         0, 0, 0, 5'd0,  1, 1, 64'h200,       0, 1, 5'd5};
    tv[9]  = '{0, 1, 0, 64'h204,       1, 0, 0, 5'd0,  1, 0, 64'h200,       0, 1, 5'd5};
    tv[10] = '{1, 1, 0, 64'h300,       1, 0, 0, 5'd0,  0, 1, RPC,           0, 0, 5'd0};
    tv[11] = '{0, 1, 1, 64'h400,       0, 0, 0, 5'd0,  1, 1, 64'h400,       0, 0, 5'd0};
    tv[12] = '{0, 1, 1, 64'h404,       1, 0, 0, 5'd0,  1, 1, 64'h404,       1, 0, 5'd0};
    tv[13] = '{0, 0, 0, 64'h0,         0, 0, 0, 5'd0,  1, 1, 64'h404,       1, 0, 5'd0};

    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    set_payload(64'hFFFF, 1'b1, 1'b1, 1'b1, 5'd31);
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", valid_o, 1'b0);
    chk("reset ready_o", ready_o, 1'b1);
    chk("reset pc_o", pc_o, RPC);
    chk("reset other outputs",
        {inst_o, alu_res_o, ram_we_o, ram_wdata_o, mem_w_wdth_o, ram_re_o, mem_r_wdth_o,
         reg_we_o, reg_waddr_o, wdate_csr_reg_o, load_pend_o, fwd_waddr_o}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      flush_i = tv[i].flush; valid_i = tv[i].valid; ready_i = tv[i].rdy;
      set_payload(tv[i].pc, tv[i].we, tv[i].re, tv[i].rwe, tv[i].wa);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d valid_o", i), valid_o, tv[i].e_valid);
      chk($sformatf("vec%0d ready_o", i), ready_o, tv[i].e_ready);
      chk($sformatf("vec%0d pc_o", i), pc_o, tv[i].e_pc);
      chk($sformatf("vec%0d ram_we_o", i), ram_we_o, tv[i].e_we);
      chk($sformatf("vec%0d load_pend_o", i), load_pend_o, tv[i].e_lp);
      chk($sformatf("vec%0d fwd_waddr_o", i), fwd_waddr_o, tv[i].e_fwd);
    end

    // Asynchronous reset while FULL: outputs must clear without a clock edge
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
    set_payload(64'h500, 1'b1, 1'b0, 1'b1, 5'd9);
    @(negedge clk);
    set_payload(64'h504, 1'b1, 1'b0, 1'b1, 5'd10);
    @(negedge clk);
    chk("pre-reset ready_o", ready_o, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst valid_o", valid_o, 1'b0);
    chk("async rst ready_o", ready_o, 1'b1);
    chk("async rst pc_o", pc_o, RPC);
    chk("async rst flags", {ram_we_o, ram_re_o, reg_we_o, load_pend_o, fwd_waddr_o}, '0);
    @(negedge clk);
    valid_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-release empty", {valid_o, ready_o}, 2'b01);
    @(negedge clk);
    valid_i = 1'b1; ready_i = 1'b0;
    set_payload(64'h600, 1'b0, 1'b0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    chk("post-release 1-cycle valid_o", valid_o, 1'b1);
    chk("post-release pc_o", pc_o, 64'h600);

    // Random handshake against a queue scoreboard, starting from a flushed block
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    next_pc = 64'h1000;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      flush_i = ($urandom_range(0, 63) == 0);
      valid_i = $urandom_range(0, 1);
      ready_i = $urandom_range(0, 1);
      set_rand_payload(next_pc);
      #1;
      chk("rand ready_o", ready_o, (sb_q.size() < 2));
      chk("rand valid_o", valid_o, (sb_q.size() != 0));
      rdy_save = ready_o;
      ready_i = ~ready_i;
      #1;
      chk("ready_o vs ready_i path", ready_o, rdy_save);
      ready_i = ~ready_i;
      #1;
      in_fire  = valid_i & ready_o;
      out_fire = valid_o & ready_i;
      if (flush_i) begin
        sb_q.delete();
      end else begin
        if (out_fire) begin
          if (sb_q.size() == 0) begin
            chk("rand spurious output", 1'b1, 1'b0);
          end else begin
            chk_entry("rand entry", sb_q[0]);
            void'(sb_q.pop_front());
          end
        end
        if (in_fire) begin
          sb_q.push_back(next_pc);
          next_pc = next_pc + 64'd4;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
